cordic_vectoring_iter: RTL and testbench

- Vectoring-mode CORDIC, the inverse direction of the rotation-mode cosine pipeline.
- Takes a fixed-point vector (x, y) and returns its angle atan2(y, x) and its CORDIC-gained magnitude.
- Iterative rather than unrolled: one micro-rotation per clock, sharing a single datapath.
- Sits after the fp_to_fixed converters and feeds a downstream consumer through a valid/ready handshake.

---
 rtl/cordic_vectoring_iter.sv | 172 +++++++++++++++++
 tb/tb_cordic_vectoring_iter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_iter.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_iter
// Iterative vectoring-mode CORDIC: one micro-rotation per clock drives the
// vector (x, y) onto the positive x axis, accumulating the angle atan2(y, x)
// in z and leaving the CORDIC-gained magnitude in x.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   input vector present
//   in_ready   block can accept a vector (high only in IDLE)
//   x_i, y_i   signed Q2.19 input vector components
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   angle_o    signed Q3.19 angle in radians, [-pi, pi]
//   mag_o      signed Q4.19 magnitude K*sqrt(x^2+y^2), K ~ 1.64676, uncompensated
// -----------------------------------------------------------------------------
module cordic_vectoring_iter #(
   parameter int WORD_LENGTH  = 21,
   parameter int N_ITERATIONS = 17
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [WORD_LENGTH-1:0] x_i,
   input  logic signed [WORD_LENGTH-1:0] y_i,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [WORD_LENGTH:0]   angle_o,
   output logic signed [WORD_LENGTH+1:0] mag_o
);

   localparam int XW = WORD_LENGTH + 2;
   localparam int ZW = WORD_LENGTH + 1;
   localparam int IW = (N_ITERATIONS > 1) ? $clog2(N_ITERATIONS) : 1;

   localparam logic [IW-1:0]        LAST_ITER = IW'(N_ITERATIONS - 1);
   localparam logic signed [ZW-1:0] PI_2      = ZW'(823550);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state_q, state_d;
   logic signed [XW-1:0]   x_q, x_d;
   logic signed [XW-1:0]   y_q, y_d;
   logic signed [ZW-1:0]   z_q, z_d;
   logic [IW-1:0]          iter_q, iter_d;
   logic                   zero_flag_q, zero_flag_d;
   logic signed [ZW-1:0]   angle_q, angle_d;
   logic signed [XW-1:0]   mag_q, mag_d;

   logic signed [XW-1:0]   x_ext, y_ext;
   logic signed [XW-1:0]   x_sh, y_sh;
   logic signed [ZW-1:0]   alpha;

   // atan(2^-i) in Q2.19, matching the existing 17-entry CORDIC table
   function automatic logic signed [ZW-1:0] atan_lut(input int i);
      case (i)
         0:       atan_lut = ZW'(411775);
         1:       atan_lut = ZW'(243085);
         2:       atan_lut = ZW'(128439);
         3:       atan_lut = ZW'(65198);
         4:       atan_lut = ZW'(32725);
         5:       atan_lut = ZW'(16379);
         6:       atan_lut = ZW'(8191);
         7:       atan_lut = ZW'(4096);
         8:       atan_lut = ZW'(2048);
         9:       atan_lut = ZW'(1024);
         10:      atan_lut = ZW'(512);
         11:      atan_lut = ZW'(256);
         12:      atan_lut = ZW'(128);
         13:      atan_lut = ZW'(64);
         14:      atan_lut = ZW'(32);
         15:      atan_lut = ZW'(16);
         16:      atan_lut = ZW'(8);
         default: atan_lut = '0;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      iter_d      = iter_q;
      zero_flag_d = zero_flag_q;
      angle_d     = angle_q;
      mag_d       = mag_q;

      // Two guard bits so that negating -2.0 and the ~1.65x gain cannot wrap
      x_ext = {{2{x_i[WORD_LENGTH-1]}}, x_i};
      y_ext = {{2{y_i[WORD_LENGTH-1]}}, y_i};
      x_sh  = x_q >>> iter_q;
      y_sh  = y_q >>> iter_q;
      alpha = atan_lut(int'(iter_q));

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Pre-rotate by +/-90 degrees so iterations start in the right half-plane
               if (!x_i[WORD_LENGTH-1]) begin
                  x_d = x_ext;
                  y_d = y_ext;
                  z_d = '0;
               end else if (!y_i[WORD_LENGTH-1]) begin
                  x_d = y_ext;
                  y_d = -x_ext;
                  z_d = PI_2;
               end else begin
                  x_d = -y_ext;
                  y_d = x_ext;
                  z_d = -PI_2;
               end
               iter_d      = '0;
               zero_flag_d = (x_i == '0) && (y_i == '0);
               state_d     = RUN;
            end
         end
         RUN: begin
            if (!y_q[XW-1]) begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + alpha;
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - alpha;
            end
            if (iter_q == LAST_ITER) begin
               // Capture the final micro-rotation straight into the output registers
               angle_d = zero_flag_q ? '0 : z_d;
               mag_d   = zero_flag_q ? '0 : x_d;
               state_d = DONE;
            end else begin
               iter_d = iter_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         iter_q      <= '0;
         zero_flag_q <= 1'b0;
         angle_q     <= '0;
         mag_q       <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         iter_q      <= iter_d;
         zero_flag_q <= zero_flag_d;
         angle_q     <= angle_d;
         mag_q       <= mag_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign angle_o   = angle_q;
   assign mag_o     = mag_q;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// -----------------------------------------------------------------------------
// tb_cordic_vectoring_iter
// Self-checking bench for cordic_vectoring_iter. Expected angles and
// magnitudes come from real-valued atan2 / sqrt and the product-form CORDIC
// gain, or from the reference constants for the directed vectors.
// -----------------------------------------------------------------------------
module tb_cordic_vectoring_iter;

   localparam int  W     = 21;
   localparam int  N     = 17;
   localparam real SCALE = 524288.0;
   localparam real PI    = 3.14159265358979323846;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [W-1:0]  x_i;
   logic signed [W-1:0]  y_i;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [W:0]    angle_o;
   logic signed [W+1:0]  mag_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cordic_vectoring_iter #(.WORD_LENGTH(W), .N_ITERATIONS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_i       (x_i),
      .y_i       (y_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .angle_o   (angle_o),
      .mag_o     (mag_o)
   );

   // ---------------- reference model ----------------
   function automatic real cordic_gain();
      real k = 1.0;
      real p = 1.0;
      for (int i = 0; i < N; i++) begin
         k = k * $sqrt(1.0 + p);
         p = p / 4.0;
      end
      return k;
   endfunction

   function automatic real model_angle(input int x, input int y);
      if (x == 0 && y == 0) return 0.0;
      return $atan2(real'(y), real'(x)) * SCALE;
   endfunction

   function automatic real model_mag(input int x, input int y);
      return cordic_gain() * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
   endfunction

   // Angle distance with wrap at +/-pi so results near the branch cut compare sanely
   function automatic real angle_dist(input int a, input real ideal);
      real d;
      d = real'(a) - ideal;
      if (d >  PI * SCALE) d = d - 2.0 * PI * SCALE;
      if (d < -PI * SCALE) d = d + 2.0 * PI * SCALE;
      return (d < 0.0) ? -d : d;
   endfunction

   function automatic real rabs(input real v);
      return (v < 0.0) ? -v : v;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic do_vector(input int x, input int y, output int ang, output int mag,
                            output int lat, output bit timed_out);
      @(negedge clk);
      in_valid = 1'b1;
      x_i      = W'(x);
      y_i      = W'(y);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble inputs after the accept edge; they must not matter any more
      x_i = W'($urandom);
      y_i = W'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      timed_out = !out_valid;
      ang = int'(angle_o);
      mag = int'(mag_o);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || angle_o !== '0 || mag_o !== '0) begin
         failures++;
         $display("FAIL reset_state got in_ready=%b out_valid=%b angle=%0d mag=%0d want 1 0 0 0",
                  in_ready, out_valid, angle_o, mag_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      int xs [4] = '{262144, -262144, -262144, 0};
      int ys [4] = '{262144, 0, -262144, 262144};
      int ea [4] = '{411775, 1647099, -1235324, 823550};
      int em [4] = '{610495, 431691, 610495, 431691};
      int ang, mag, lat;
      bit to;
      for (int i = 0; i < 4; i++) begin
         do_vector(xs[i], ys[i], ang, mag, lat, to);
         checks++;
         if (to || lat != N) begin
            failures++;
            $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, N);
         end
         checks++;
         if (angle_dist(ang, real'(ea[i])) > 16.0) begin
            failures++;
            $display("FAIL directed_angle[%0d] got=%0d want=%0d+/-16", i, ang, ea[i]);
         end
         checks++;
         if (rabs(real'(mag - em[i])) > 32.0) begin
            failures++;
            $display("FAIL directed_mag[%0d] got=%0d want=%0d+/-32", i, mag, em[i]);
         end
         release_result();
      end
   endtask

   task automatic test_zero();
      int ang, mag, lat;
      bit to;
      do_vector(0, 0, ang, mag, lat, to);
      checks++;
      if (to || lat != N) begin
         failures++;
         $display("FAIL zero_latency got=%0d want=%0d", lat, N);
      end
      checks++;
      if (ang != 0 || mag != 0) begin
         failures++;
         $display("FAIL zero_result got angle=%0d mag=%0d want 0 0", ang, mag);
      end
      release_result();
   endtask

   task automatic test_boundary();
      int xs [5] = '{-1048576, -1048576, 1048575, 0, -1048576};
      int ys [5] = '{0, -1048576, 1048575, -1048576, 1048575};
      int ang, mag, lat;
      bit to;
      for (int i = 0; i < 5; i++) begin
         do_vector(xs[i], ys[i], ang, mag, lat, to);
         checks++;
         if (to || angle_dist(ang, model_angle(xs[i], ys[i])) > 16.0) begin
            failures++;
            $display("FAIL boundary_angle[%0d] got=%0d want=%0.1f+/-16", i, ang,
                     model_angle(xs[i], ys[i]));
         end
         checks++;
         if (rabs(real'(mag) - model_mag(xs[i], ys[i])) > 32.0) begin
            failures++;
            $display("FAIL boundary_mag[%0d] got=%0d want=%0.1f+/-32", i, mag,
                     model_mag(xs[i], ys[i]));
         end
         release_result();
      end
   endtask

   task automatic test_random();
      int x, y, ang, mag, lat;
      bit to;
      for (int i = 0; i < 24; i++) begin
         // Keep |v| >= 0.5 so quantisation of tiny vectors does not dominate
         do begin
            x = int'($urandom_range(2097151, 0)) - 1048576;
            y = int'($urandom_range(2097151, 0)) - 1048576;
         end while ($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) < 262144.0);
         do_vector(x, y, ang, mag, lat, to);
         checks++;
         if (to || lat != N) begin
            failures++;
            $display("FAIL random_latency[%0d] got=%0d want=%0d", i, lat, N);
         end
         checks++;
         if (angle_dist(ang, model_angle(x, y)) > 16.0) begin
            failures++;
            $display("FAIL random_angle[%0d] x=%0d y=%0d got=%0d want=%0.1f+/-16", i, x, y,
                     ang, model_angle(x, y));
         end
         checks++;
         if (rabs(real'(mag) - model_mag(x, y)) > 32.0) begin
            failures++;
            $display("FAIL random_mag[%0d] x=%0d y=%0d got=%0d want=%0.1f+/-32", i, x, y,
                     mag, model_mag(x, y));
         end
         release_result();
      end
   endtask

   task automatic test_back_to_back();
      int ang, mag, lat, hold_a, hold_m;
      bit to;
      do_vector(262144, 262144, ang, mag, lat, to);
      hold_a = ang;
      hold_m = mag;
      checks++;
      if (to) begin
         failures++;
         $display("FAIL bp_first_timeout got out_valid=%b want 1", out_valid);
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         in_valid = (c == 1);
         x_i      = W'(-524288);
         y_i      = W'(100000);
         checks++;
         if (int'(angle_o) != hold_a || int'(mag_o) != hold_m || in_ready !== 1'b0 ||
             out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold[%0d] got angle=%0d mag=%0d in_ready=%b out_valid=%b want %0d %0d 0 1",
                     c, angle_o, mag_o, in_ready, out_valid, hold_a, hold_m);
         end
      end
      in_valid = 1'b0;
      release_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      do_vector(0, -262144, ang, mag, lat, to);
      checks++;
      if (to || lat != N || angle_dist(ang, -823550.0) > 16.0) begin
         failures++;
         $display("FAIL bp_second_angle got=%0d lat=%0d want=-823550+/-16 lat=%0d", ang, lat, N);
      end
      checks++;
      if (rabs(real'(mag - 431691)) > 32.0) begin
         failures++;
         $display("FAIL bp_second_mag got=%0d want=431691+/-32", mag);
      end
      release_result();
   endtask

   task automatic test_reset_mid_run();
      int ang, mag, lat;
      bit to;
      @(negedge clk);
      in_valid = 1'b1;
      x_i      = W'(262144);
      y_i      = W'(-131072);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || angle_o !== '0 || mag_o !== '0) begin
         failures++;
         $display("FAIL midrun_reset got in_ready=%b out_valid=%b angle=%0d mag=%0d want 1 0 0 0",
                  in_ready, out_valid, angle_o, mag_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_vector(524288, 0, ang, mag, lat, to);
      checks++;
      if (to || lat != N || angle_dist(ang, 0.0) > 16.0) begin
         failures++;
         $display("FAIL post_reset_angle got=%0d lat=%0d want=0+/-16 lat=%0d", ang, lat, N);
      end
      checks++;
      if (rabs(real'(mag - 863381)) > 32.0) begin
         failures++;
         $display("FAIL post_reset_mag got=%0d want=863381+/-32", mag);
      end
      release_result();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x_i       = '0;
      y_i       = '0;
      test_reset();
      test_directed();
      test_zero();
      test_boundary();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
